demux_1x8_nbit_stream: RTL and testbench
========================================

DEMUX_1X8_NBIT_STREAM -- requirements
Module: demux_1x8_nbit_stream

Interface
REQ-001 Parameter: N, default 3, data word width in bits, N >= 1.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: w  input  N  incoming data word.
REQ-005 Port: s  input  3  explicit destination channel index, used when auto_mode=0.
REQ-006 Port: auto_mode  input  1  1 = destination from internal round-robin pointer; 0 = destination from s.
REQ-007 Port: in_valid  input  1  upstream word w is valid.
REQ-008 Port: in_ready  output  1  block can accept a word this cycle.
REQ-009 Port: f0..f7  output  N each  registered output word for channels 0..7.
REQ-010 Port: f_valid  output  8  bit k = channel k holds a valid word.
REQ-011 Port: f_ready  input  8  bit k = downstream consumer k accepts fk this cycle.
REQ-012 Port: ptr  output  3  current round-robin pointer value.
REQ-013 Port: cnt  output  8  total accepted words, modulo 256.
REQ-014 Port: busy  output  1  OR of all f_valid bits.

Function
REQ-015 Destination dest SHALL be ptr when auto_mode=1, else s; evaluated combinationally each cycle.
REQ-016 in_ready SHALL be combinational: !f_valid[dest] | f_ready[dest].
REQ-017 Accept SHALL occur when in_valid & in_ready at a rising edge.
REQ-018 On accept: f<dest> <= w; f_valid[dest] <= 1; word visible on the output the cycle after accept (latency 1).
REQ-019 Channel k consume SHALL occur when f_valid[k] & f_ready[k]; on consume without a same-cycle load into k, f_valid[k] <= 0 and fk holds its last value.
REQ-020 Simultaneous consume and load on the same channel: f_valid[k] stays 1, fk takes the new word, no bubble, no loss.
REQ-021 Non-destination channels SHALL be unaffected by an accept; each channel's consume is independent of the others.
REQ-022 f_ready[k] while f_valid[k]=0 SHALL have no effect.
REQ-023 ptr SHALL increment by 1 on every accept with auto_mode=1, wrapping 7 -> 0; it SHALL hold on stall, on no accept, and on accepts with auto_mode=0.
REQ-024 auto_mode changes SHALL take effect on dest in the same cycle; ptr SHALL retain its value across mode changes.
REQ-025 cnt SHALL increment by 1 on every accept in either mode, wrapping 255 -> 0.
REQ-026 While in_valid=1 and in_ready=0 (stall), no state SHALL change for the input path; upstream holds w, s and auto_mode stable until accept.
REQ-027 in_valid=0 SHALL leave f0..f7, f_valid, ptr and cnt unchanged except for consumes.
REQ-028 busy SHALL be combinational from the registered f_valid.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, force f0..f7=0, f_valid=8'h00, ptr=0, cnt=0, busy=0.
REQ-030 Reset mid-operation SHALL discard all held words; no word accepted before reset SHALL appear after reset.
REQ-031 The first accept SHALL occur no earlier than the first rising edge after rst_n deasserts.
REQ-032 in_ready during reset SHALL equal 1, because all f_valid bits are 0.

Verification
REQ-033 Bench SHALL cover: auto_mode=0, N=3, f_ready=8'hFF, send w=5 with s=6 -> next cycle f6=5, f_valid=8'h40, cnt=1; following cycle with in_valid=0 -> f_valid=8'h00.
REQ-034 Bench SHALL cover: auto_mode=1, f_ready=8'hFF, 10 back-to-back words 0..7,0,1 -> channels 0..7 each receive their index, then f0=0 and f1=1; ptr=2, cnt=10.
REQ-035 Bench SHALL cover: f_ready=0, s=3, two words 1 then 2 -> first accepted, in_ready=0 while s=3, f3 stays 1; raise f_ready[3] -> f3=2 next cycle, f_valid[3] stays 1.
REQ-036 Bench SHALL cover: channel 2 full and stalled, present s=4 -> in_ready=1, word lands in f4; f2 unchanged.
REQ-037 Bench SHALL cover: 256 accepts -> cnt wraps to 0; ptr after 256 auto-mode accepts = 0.
REQ-038 Bench SHALL cover: f_valid=8'hFF, assert rst_n=0 between clock edges -> all outputs 0 immediately; after release, the next word goes to ptr=0 under auto_mode=1.

Source files
------------

// File: rtl/demux_1x8_nbit_stream.sv
// Purpose: route one N-bit stream word to one of eight registered output channels (explicit index or round-robin).
// Latency: 1 cycle from accept to the word being visible on f<dest>.
// Backpressure: in_ready drops only when the selected channel is full and its consumer is not taking the word.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   w, in_valid         incoming word and its valid
//   in_ready            combinational: selected channel is empty or draining this cycle
//   s, auto_mode        explicit channel index, or 1 = use round-robin pointer
//   f0..f7, f_valid     per-channel held word and valid bit
//   f_ready             per-channel consumer accept
//   ptr, cnt, busy      round-robin pointer, accepted-word count (mod 256), any channel occupied
module demux_1x8_nbit_stream #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] w,
    input  logic [2:0]   s,
    input  logic         auto_mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] f0,
    output logic [N-1:0] f1,
    output logic [N-1:0] f2,
    output logic [N-1:0] f3,
    output logic [N-1:0] f4,
    output logic [N-1:0] f5,
    output logic [N-1:0] f6,
    output logic [N-1:0] f7,
    output logic [7:0]   f_valid,
    input  logic [7:0]   f_ready,
    output logic [2:0]   ptr,
    output logic [7:0]   cnt,
    output logic         busy
);

    logic [N-1:0] f_q [8];
    logic [2:0]   dest;
    logic         accept;
    logic [7:0]   load;
    logic [7:0]   consume;

    always_comb begin
        dest     = auto_mode ? ptr : s;
        // A full channel can still take a new word if its consumer drains it in the same cycle.
        in_ready = !f_valid[dest] || f_ready[dest];
        accept   = in_valid && in_ready;
        load     = accept ? (8'b1 << dest) : 8'h00;
        consume  = f_valid & f_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                f_q[k] <= '0;
            end
            f_valid <= 8'h00;
            ptr     <= 3'd0;
            cnt     <= 8'd0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (load[k]) begin
                    f_q[k] <= w;
                end
            end
            // Load wins over consume so a simultaneous drain+refill keeps the channel valid.
            f_valid <= load | (f_valid & ~consume);
            if (accept) begin
                cnt <= cnt + 8'd1;
                if (auto_mode) begin
                    ptr <= ptr + 3'd1;
                end
            end
        end
    end

    assign f0   = f_q[0];
    assign f1   = f_q[1];
    assign f2   = f_q[2];
    assign f3   = f_q[3];
    assign f4   = f_q[4];
    assign f5   = f_q[5];
    assign f6   = f_q[6];
    assign f7   = f_q[7];
    assign busy = |f_valid;

endmodule

// File: tb/tb_demux_1x8_nbit_stream.sv
// Purpose: scoreboard bench for demux_1x8_nbit_stream (directed scenarios plus constrained-random traffic).
// Latency: model expects a word on f<dest> one cycle after accept.
// Backpressure: upstream holds w/s/auto_mode stable while stalled; consumers ready randomly.
module tb_demux_1x8_nbit_stream;

    localparam int N = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] w;
    logic [2:0]   s;
    logic         auto_mode;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] f0, f1, f2, f3, f4, f5, f6, f7;
    logic [7:0]   f_valid;
    logic [7:0]   f_ready;
    logic [2:0]   ptr;
    logic [7:0]   cnt;
    logic         busy;

    demux_1x8_nbit_stream #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .w(w), .s(s), .auto_mode(auto_mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .f0(f0), .f1(f1), .f2(f2), .f3(f3), .f4(f4), .f5(f5), .f6(f6), .f7(f7),
        .f_valid(f_valid), .f_ready(f_ready), .ptr(ptr), .cnt(cnt), .busy(busy)
    );

    wire [N-1:0] fo [8];
    assign fo[0] = f0;
    assign fo[1] = f1;
    assign fo[2] = f2;
    assign fo[3] = f3;
    assign fo[4] = f4;
    assign fo[5] = f5;
    assign fo[6] = f6;
    assign fo[7] = f7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: each channel is a slot that is either empty or holds one pending word;
    // words the consumer should see are queued per channel in arrival order.
    logic [N-1:0] exp_q [8][$];
    logic [7:0]   m_valid;
    int           m_ptr;
    int           m_cnt;
    bit           m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 8'h00;
            m_ptr   = 0;
            m_cnt   = 0;
            m_acc   = 0;
            for (int k = 0; k < 8; k++) exp_q[k].delete();
        end else begin
            int d;
            bit rdy;
            d     = auto_mode ? m_ptr : int'(s);
            rdy   = !m_valid[d] || f_ready[d];
            m_acc = in_valid && rdy;
            m_valid = m_valid & ~f_ready;
            if (m_acc) begin
                m_valid[d] = 1'b1;
                exp_q[d].push_back(w);
                m_cnt = (m_cnt + 1) % 256;
                if (auto_mode) m_ptr = (m_ptr + 1) % 8;
            end
        end
    end

    // Monitor: compare architectural outputs to the model and pop a word whenever a consumer takes one.
    always @(negedge clk) begin
        if (rst_n) begin
            int  d;
            bit  exp_rdy;
            logic [N-1:0] e;
            d       = auto_mode ? m_ptr : int'(s);
            exp_rdy = !m_valid[d] || f_ready[d];
            check("f_valid", 32'(f_valid), 32'(m_valid));
            check("ptr", 32'(ptr), 32'(m_ptr));
            check("cnt", 32'(cnt), 32'(m_cnt));
            check("busy", 32'(busy), 32'(m_valid != 8'h00));
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            for (int k = 0; k < 8; k++) begin
                if (f_valid[k] && f_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("spurious_word_f%0d", k), 32'(fo[k]), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q[k].pop_front();
                        check($sformatf("data_f%0d", k), 32'(fo[k]), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #3;
        rst_n    = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; w = '0; s = '0; auto_mode = 1'b0; in_valid = 1'b0; f_ready = 8'h00;
        #1;
        check("rst_f_valid", 32'(f_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_cnt", 32'(cnt), 0);
        tick();
        do_reset();

        // Explicit index, single word, drained next cycle.
        auto_mode = 1'b0; f_ready = 8'hFF; w = 3'd5; s = 3'd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_f6", 32'(f6), 5);
        check("t1_f_valid", 32'(f_valid), 32'h40);
        check("t1_cnt", 32'(cnt), 1);
        tick();
        check("t1_drain", 32'(f_valid), 0);

        // Round-robin, ten back-to-back words.
        do_reset();
        auto_mode = 1'b1; f_ready = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            w = N'(i % 8); in_valid = 1'b1;
            tick();
            check($sformatf("t2_f%0d", i % 8), 32'(fo[i % 8]), 32'(i % 8));
        end
        in_valid = 1'b0;
        check("t2_ptr", 32'(ptr), 2);
        check("t2_cnt", 32'(cnt), 10);

        // Stall on a full channel, then drain+refill in the same cycle.
        do_reset();
        auto_mode = 1'b0; f_ready = 8'h00; s = 3'd3; w = 3'd1; in_valid = 1'b1;
        tick();
        w = 3'd2;
        #1;
        for (int j = 0; j < 3; j++) begin
            check("t3_stall_rdy", 32'(in_ready), 0);
            check("t3_f3_hold", 32'(f3), 1);
            tick();
        end
        f_ready = 8'h08;
        tick();
        in_valid = 1'b0;
        check("t3_f3_new", 32'(f3), 2);
        check("t3_f3_valid", 32'(f_valid[3]), 1);
        tick();
        f_ready = 8'h00;

        // A stalled channel does not block a different destination.
        do_reset();
        auto_mode = 1'b0; f_ready = 8'h00; s = 3'd2; w = 3'd6; in_valid = 1'b1;
        tick();
        s = 3'd4; w = 3'd3;
        #1;
        check("t4_rdy", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("t4_f4", 32'(f4), 3);
        check("t4_f2", 32'(f2), 6);
        check("t4_f_valid", 32'(f_valid), 32'h14);

        // 256 round-robin accepts wrap both counters.
        do_reset();
        auto_mode = 1'b1; f_ready = 8'hFF; in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = N'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("t5_cnt_wrap", 32'(cnt), 0);
        check("t5_ptr_wrap", 32'(ptr), 0);

        // Random traffic; upstream holds its word while stalled.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            f_ready = 8'($urandom | $urandom);
            if (!(in_valid && !m_acc)) begin
                in_valid  = ($urandom % 4) != 0;
                w         = N'($urandom);
                s         = 3'($urandom);
                auto_mode = 1'($urandom);
            end
            tick();
        end
        in_valid = 1'b0;

        // Fill all channels, then reset between clock edges.
        do_reset();
        auto_mode = 1'b1; f_ready = 8'h00; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = N'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        check("t6_full", 32'(f_valid), 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_f_valid", 32'(f_valid), 0);
        check("t6_rst_ptr", 32'(ptr), 0);
        check("t6_rst_cnt", 32'(cnt), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_in_ready", 32'(in_ready), 1);
        for (int k = 0; k < 8; k++) check($sformatf("t6_rst_f%0d", k), 32'(fo[k]), 0);
        tick();
        check("t6_rst_hold", 32'(f_valid), 0);
        #2;
        rst_n = 1'b1;
        tick();
        w = 3'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t6_post_f0", 32'(f0), 5);
        check("t6_post_f_valid", 32'(f_valid), 32'h01);
        check("t6_post_ptr", 32'(ptr), 1);

        // Drain everything; every accepted word must have been delivered.
        f_ready = 8'hFF;
        tick();
        tick();
        for (int k = 0; k < 8; k++) check($sformatf("undelivered_f%0d", k), exp_q[k].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
